// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display scanner: one shared 7-segment decoder, frame-aligned
// value updates through a valid/ready port, leading-zero blanking and dead time.
module hex_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    blank_lz,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic                    load_ready,
   output logic [3:0]              nib_out,
   input  logic [6:0]              seg_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int VAL_W = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [VAL_W-1:0]      shadow_q, shadow_d;
   logic [VAL_W-1:0]      pending_q, pending_d;
   logic                  pend_full_q, pend_full_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  frame_done_q, frame_done_d;

   logic boundary;
   logic lit;
   logic blank_cur;
   logic lz_run;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      div_d        = div_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      pend_full_d  = pend_full_q;
      an_d         = '1;
      seg_d        = 7'h7F;
      nib_out      = 4'h0;
      blank_cur    = 1'b0;
      lz_run       = 1'b1;

      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) nib_out = shadow_q[4*k +: 4];
      end

      // Walk down from the most significant digit; a digit is blanked while every nibble above and including it is zero.
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lz_run = lz_run && (shadow_q[4*k +: 4] == 4'h0);
         if (blank_lz && lz_run && (idx_q == IDX_W'(k))) blank_cur = 1'b1;
      end

      boundary     = (state_q == SCAN) && enable && (div_q == DIV_LAST) && (idx_q == IDX_LAST);
      lit          = (state_q == SCAN) && enable && (div_q != '0);
      frame_done_d = boundary;

      if (lit) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) an_d[k] = 1'b0;
         end
         seg_d = blank_cur ? 7'h7F : seg_in;
      end

      case (state_q)
         IDLE: begin
            idx_d = '0;
            div_d = '0;
            if (enable) state_d = SCAN;
         end
         SCAN: begin
            if (!enable) begin
               state_d = IDLE;
               idx_d   = '0;
               div_d   = '0;
            end else if (div_q == DIV_LAST) begin
               div_d = '0;
               idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pending only reaches the shadow when no frame is in progress, so digits never tear.
      if (pend_full_q && ((state_q == IDLE) || boundary)) begin
         shadow_d    = pending_q;
         pend_full_d = 1'b0;
      end
      if (load_valid && !pend_full_q) begin
         pending_d   = load_value;
         pend_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         div_q        <= '0;
         shadow_q     <= '0;
         pend_full_q  <= 1'b0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         div_q        <= div_d;
         shadow_q     <= shadow_d;
         pend_full_q  <= pend_full_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      pending_q <= pending_d;
   end

   assign load_ready = !pend_full_q;
   assign an_out     = an_q;
   assign seg_out    = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: a time-based display model predicts every
// cycle's outputs; a monitor compares them against the DUT one cycle later.
module tb_hex_scan_ctrl;

   localparam int N = 4;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          blank_lz = 1'b0;
   logic          load_valid = 1'b0;
   logic [4*N-1:0] load_value = '0;
   logic          load_ready;
   logic [3:0]    nib_out;
   logic [6:0]    seg_in;
   logic [6:0]    seg_out;
   logic [N-1:0]  an_out;
   logic          frame_done;

   hex_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
      .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz),
      .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
      .nib_out(nib_out), .seg_in(seg_in), .seg_out(seg_out), .an_out(an_out),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
      endcase
   endfunction

   // External shared decoder
   assign seg_in = hex7(nib_out);

   typedef struct {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         fd;
      logic         rdy;
      logic [3:0]   nib;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: time since scan start instead of digit/divider counters
   bit           m_scan = 0;
   int           m_t = 0;
   logic [4*N-1:0] m_shadow = '0;
   logic [4*N-1:0] m_pend = '0;
   bit           m_pfull = 0;

   function automatic logic [3:0] nib_of(input logic [4*N-1:0] v, input int i);
      logic [4*N-1:0] s;
      s = v >> (4 * i);
      return s[3:0];
   endfunction

   task automatic step(input logic r, input logic e, input logic b, input logic v,
                       input logic [4*N-1:0] val);
      exp_t x;
      int   idx, dv, nidx;
      bit   lit, bnd, blanked;
      logic [4*N-1:0] above;
      @(negedge clk); #1;
      rst = r; enable = e; blank_lz = b; load_valid = v; load_value = val;
      if (r) begin
         m_scan = 0; m_t = 0; m_shadow = '0; m_pfull = 0;
         x.an = '1; x.seg = 7'h7F; x.fd = 1'b0;
      end else begin
         idx = m_scan ? (m_t / D) % N : 0;
         dv  = m_scan ? m_t % D : 0;
         lit = m_scan && e && (dv != 0);
         bnd = m_scan && e && (dv == D - 1) && (idx == N - 1);
         above = m_shadow >> (4 * idx);
         blanked = b && (idx >= 1) && (above == '0);
         x.an  = lit ? ~(N'(1) << idx) : '1;
         x.seg = !lit ? 7'h7F : (blanked ? 7'h7F : hex7(nib_of(m_shadow, idx)));
         x.fd  = bnd;
         if (m_pfull && (!m_scan || bnd)) begin
            m_shadow = m_pend;
            m_pfull  = 0;
         end else if (v && !m_pfull) begin
            m_pend  = val;
            m_pfull = 1;
         end
         if (m_scan) begin
            if (e) m_t = (m_t + 1) % (N * D);
            else begin m_scan = 0; m_t = 0; end
         end else if (e) begin
            m_scan = 1; m_t = 0;
         end
      end
      nidx  = m_scan ? (m_t / D) % N : 0;
      x.rdy = !m_pfull;
      x.nib = nib_of(m_shadow, nidx);
      exp_q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk); #2;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (an_out !== x.an || seg_out !== x.seg || frame_done !== x.fd ||
                load_ready !== x.rdy || nib_out !== x.nib) begin
               miscompares++;
               $display("FAIL outputs @%0t: got an=%b seg=%h fd=%b rdy=%b nib=%h, want an=%b seg=%h fd=%b rdy=%b nib=%h",
                        $time, an_out, seg_out, frame_done, load_ready, nib_out,
                        x.an, x.seg, x.fd, x.rdy, x.nib);
            end
         end
      end
   end

   initial begin : stim
      logic [4*N-1:0] rv;
      logic e, b;
      int guard;
      // Reset then plain scanning of zero
      repeat (3) step(1, 0, 0, 0, '0);
      repeat (40) step(0, 1, 0, 0, '0);
      // Load while idle, then scan 1234
      repeat (2) step(0, 0, 0, 0, '0);
      step(0, 0, 0, 1, 16'h1234);
      repeat (3) step(0, 0, 0, 0, '0);
      repeat (20) step(0, 1, 0, 0, '0);
      // Mid-frame load at digit 1, div 1
      guard = 0;
      while (!(m_scan && m_t == D + 1) && guard < 64) begin
         step(0, 1, 0, 0, '0); guard++;
      end
      step(0, 1, 0, 1, 16'h5678);
      repeat (24) step(0, 1, 0, 1, 16'h9ABC);
      // Leading-zero blanking
      step(0, 1, 1, 1, 16'h0050);
      repeat (36) step(0, 1, 1, 0, '0);
      step(0, 1, 1, 1, 16'h0000);
      repeat (36) step(0, 1, 1, 0, '0);
      step(0, 1, 1, 1, 16'h0708);
      repeat (20) step(0, 1, 1, 0, '0);
      // Drop enable at digit 2, then re-enable
      guard = 0;
      while (!(m_scan && (m_t / D) % N == 2) && guard < 64) begin
         step(0, 1, 0, 0, '0); guard++;
      end
      repeat (3) step(0, 0, 0, 0, '0);
      repeat (20) step(0, 1, 0, 0, '0);
      // Reset with pending full mid-frame
      step(0, 1, 0, 1, 16'hDEAD);
      step(0, 1, 0, 0, '0);
      step(1, 1, 0, 0, '0);
      repeat (20) step(0, 1, 0, 0, '0);
      // Randomized traffic
      e = 1'b1; b = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < N; k++) rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 39) == 0) e = ~e;
         if ($urandom_range(0, 59) == 0) b = ~b;
         step(($urandom_range(0, 199) == 0), e, b, ($urandom_range(0, 3) == 0), rv);
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk); guard++;
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
